// File: rtl/period_to_rpm_pkg.sv
// rtl/period_to_rpm_pkg.sv - shared width, state encoding and sizing helpers for period_to_rpm
package period_to_rpm_pkg;

  // Width of the averaged period delivered by the upstream rpm stage.
  localparam int RPM_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Divisor width: period scaled by pulses per revolution.
  function automatic int calc_div_w(input int ppr);
    return RPM_WIDTH + $clog2(ppr + 1);
  endfunction

  // Divider step count: wide enough for numerator or divisor, plus one
  // headroom bit so the rounding add cannot overflow the numerator.
  function automatic int calc_iter(input longint unsigned clk_hz, input int ppr);
    longint unsigned num;
    int nb;
    int dw;
    num = 64'd60 * clk_hz;
    nb  = $clog2(num + 1);
    dw  = calc_div_w(ppr);
    return ((nb > dw) ? nb : dw) + 1;
  endfunction

endpackage

// File: rtl/serial_divider.sv
// rtl/serial_divider.sv - bit-serial restoring divider, one quotient bit per step, MSB first
module serial_divider #(
  parameter int ITER  = 18,
  parameter int DIV_W = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic [ITER-1:0]  numerator,
  input  logic [DIV_W-1:0] divisor,
  output logic [ITER-1:0]  quotient,
  output logic             last
);

  localparam int CW = $clog2(ITER + 1);

  logic [ITER-1:0]  num_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] rem_q;
  logic [ITER-1:0]  quo_q;
  logic [CW-1:0]    cnt_q;
  logic [DIV_W:0]   rem_shift;
  logic             ge;

  // Trial subtraction: bring down the next numerator bit and compare.
  always_comb begin
    rem_shift = {rem_q, num_q[ITER-1]};
    ge        = (rem_shift >= {1'b0, div_q});
  end

  // Load operands on start, then shift/subtract once per step.
  always_ff @(posedge clk) begin
    if (!reset) begin
      num_q <= '0;
      div_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      num_q <= numerator;
      div_q <= divisor;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= CW'(ITER);
    end else if (step) begin
      num_q <= num_q << 1;
      rem_q <= DIV_W'(ge ? (rem_shift - {1'b0, div_q}) : rem_shift);
      quo_q <= {quo_q[ITER-2:0], ge};
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign quotient = quo_q;
  assign last     = (cnt_q == CW'(1));

endmodule

// File: rtl/period_to_rpm.sv
// rtl/period_to_rpm.sv - averaged pulse period to RPM; PERIOD_TO_RPM_ROUND_EN selects round-to-nearest
module period_to_rpm
  import period_to_rpm_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int          PULSES_PER_REV = 1,
  parameter int          OUT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [RPM_WIDTH-1:0] period,
  input  logic                 period_valid,
  output logic                 busy,
  output logic [OUT_WIDTH-1:0] rpm,
  output logic                 rpm_valid,
  output logic                 overflow
);

  localparam int DIV_W = calc_div_w(PULSES_PER_REV);
  localparam int ITER  = calc_iter(64'(CLK_HZ), PULSES_PER_REV);
  localparam logic [ITER-1:0] NUM_BASE = ITER'(64'(CLK_HZ) * 64'd60);

  state_t          state;
  logic            zero_q;
  logic            start;
  logic            step;
  logic            div_last;
  logic            sat;
  logic [DIV_W-1:0] divisor_in;
  logic [ITER-1:0]  numerator_in;
  logic [ITER-1:0]  quotient;

  // Operand preparation for the sample being accepted this cycle.
  always_comb begin
    start      = (state == S_IDLE) && period_valid;
    step       = (state == S_DIVIDE);
    divisor_in = DIV_W'(period) * DIV_W'(PULSES_PER_REV);
`ifdef PERIOD_TO_RPM_ROUND_EN
    numerator_in = NUM_BASE + ITER'(divisor_in >> 1);
`else
    numerator_in = NUM_BASE;
`endif
    sat        = |(quotient >> OUT_WIDTH);
  end

  serial_divider #(
    .ITER  (ITER),
    .DIV_W (DIV_W)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .step      (step),
    .numerator (numerator_in),
    .divisor   (divisor_in),
    .quotient  (quotient),
    .last      (div_last)
  );

  // Conversion sequencing plus zero/saturation handling into the output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      zero_q    <= 1'b0;
      busy      <= 1'b0;
      rpm       <= '0;
      rpm_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      rpm_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (period_valid) begin
            zero_q <= (period == '0);
            busy   <= 1'b1;
            state  <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          if (div_last) state <= S_DONE;
        end
        S_DONE: begin
          if (zero_q) begin
            rpm      <= '0;
            overflow <= 1'b0;
          end else if (sat) begin
            rpm      <= '1;
            overflow <= 1'b1;
          end else begin
            rpm      <= OUT_WIDTH'(quotient);
            overflow <= 1'b0;
          end
          rpm_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_period_to_rpm.sv
// tb/tb_period_to_rpm.sv - scoreboard bench for period_to_rpm, 16-bit and 12-bit output builds
module tb_period_to_rpm;

  localparam int CLK_HZ   = 1000;
  localparam int PPR      = 1;
  localparam int NUM_BITS = $clog2(60 * CLK_HZ + 1);
  localparam int DIVW     = 16 + $clog2(PPR + 1);
  localparam int ITER     = ((NUM_BITS > DIVW) ? NUM_BITS : DIVW) + 1;
  localparam int LAT      = ITER + 1;
`ifdef PERIOD_TO_RPM_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  typedef struct {
    longint rpm;
    longint ovf;
    longint cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] period = '0;
  logic [15:0] period2 = '0;
  logic        period_valid = 1'b0;
  logic        valid2 = 1'b0;
  logic        busy, rpm_valid, overflow;
  logic [15:0] rpm;
  logic        busy2, rpm_valid2, overflow2;
  logic [11:0] rpm2;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   a;
  exp_t q16[$];
  exp_t q12[$];
  exp_t e16, e12;

  period_to_rpm #(.CLK_HZ(CLK_HZ), .PULSES_PER_REV(PPR), .OUT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .period(period), .period_valid(period_valid),
    .busy(busy), .rpm(rpm), .rpm_valid(rpm_valid), .overflow(overflow)
  );

  period_to_rpm #(.CLK_HZ(CLK_HZ), .PULSES_PER_REV(PPR), .OUT_WIDTH(12)) dut12 (
    .clk(clk), .reset(reset), .period(period2), .period_valid(valid2),
    .busy(busy2), .rpm(rpm2), .rpm_valid(rpm_valid2), .overflow(overflow2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int p, input int ow, input int at);
    exp_t   e;
    longint num = 60 * CLK_HZ + (ROUND ? p / 2 : 0);
    longint lim = (longint'(1) << ow) - 1;
    if (p == 0) begin
      e.rpm = 0; e.ovf = 0;
    end else if (num / p > lim) begin
      e.rpm = lim; e.ovf = 1;
    end else begin
      e.rpm = num / p; e.ovf = 0;
    end
    e.cyc = at + LAT;
    return e;
  endfunction

  // 16-bit instance result checker
  always @(negedge clk) begin
    if (rpm_valid) begin
      if (q16.size() == 0) check("spurious_strobe16", 1, 0);
      else begin
        e16 = q16.pop_front();
        check("rpm16", 64'(rpm), e16.rpm);
        check("ovf16", 64'(overflow), e16.ovf);
        check("latency16", cyc, e16.cyc);
        check("busy_at_done16", 64'(busy), 0);
      end
    end
  end

  // 12-bit instance result checker
  always @(negedge clk) begin
    if (rpm_valid2) begin
      if (q12.size() == 0) check("spurious_strobe12", 1, 0);
      else begin
        e12 = q12.pop_front();
        check("rpm12", 64'(rpm2), e12.rpm);
        check("ovf12", 64'(overflow2), e12.ovf);
        check("latency12", cyc, e12.cyc);
      end
    end
  end

  task automatic send16(input int p);
    @(negedge clk);
    period = 16'(p);
    period_valid = 1'b1;
    q16.push_back(model(p, 16, cyc + 1));
    @(negedge clk);
    period_valid = 1'b0;
    check("busy_running16", 64'(busy), 1);
  endtask

  task automatic send12(input int p);
    @(negedge clk);
    period2 = 16'(p);
    valid2 = 1'b1;
    q12.push_back(model(p, 12, cyc + 1));
    @(negedge clk);
    valid2 = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (q16.size() == 0 && q12.size() == 0) break;
      @(negedge clk);
    end
    check("drain_timeout", q16.size() + q12.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    period = 16'd600;
    period_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rpm", 64'(rpm), 0);
    check("reset_valid", 64'(rpm_valid), 0);
    check("reset_busy", 64'(busy), 0);
    check("reset_ovf", 64'(overflow), 0);

    reset = 1'b1;
    q16.push_back(model(600, 16, cyc + 1));
    @(negedge clk);
    period_valid = 1'b0;
    drain();

    send16(600); drain();
    send16(9);   drain();
    send16(8);   drain();
    send16(0);   drain();
    send12(9);   drain();
    send12(600); drain();

    @(negedge clk);
    period = 16'd600;
    period_valid = 1'b1;
    a = cyc + 1;
    q16.push_back(model(600, 16, a));
    q16.push_back(model(300, 16, a + ITER + 2));
    repeat (5) @(negedge clk);
    period = 16'd300;
    while (cyc < a + ITER + 2) @(negedge clk);
    period_valid = 1'b0;
    drain();

    @(negedge clk);
    period = 16'd600;
    period_valid = 1'b1;
    a = cyc + 1;
    @(negedge clk);
    period_valid = 1'b0;
    while (cyc < a + 5) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_busy", 64'(busy), 0);
    check("abort_rpm", 64'(rpm), 0);
    check("abort_ovf", 64'(overflow), 0);
    check("abort_valid", 64'(rpm_valid), 0);
    reset = 1'b1;
    repeat (LAT + 5) @(negedge clk);
    send16(300); drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
